// File: rtl/gpio_pkg.sv
// Shared types and constants for the GPIO pulse arbiter: FSM states,
// default widths and the round-robin pointer update helper.
package gpio_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int DEF_CNT_W      = 16;
    localparam int DEF_GAP_CYCLES = 4;
    localparam int NUM_REQ        = 2;

    // After a grant, priority passes to the requester that did not win.
    function automatic logic rr_next_ptr(input logic [NUM_REQ-1:0] grant);
        return grant[0];
    endfunction

endpackage

// File: rtl/gpio_rr_arb.sv
// Two-way round-robin selector: purely combinational, one-hot grant out.
// ptr names the requester that wins when both are asserted.
module gpio_rr_arb
    import gpio_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               ptr,
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        grant = '0;
        if (req == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/gpio_pulse_arbiter.sv
// Shares one GPIO pin between two requesters: each grant drives a pulse of the
// requested length followed by a forced low gap before the next arbitration.
module gpio_pulse_arbiter
    import gpio_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [CNT_W-1:0]   i_len0,
    input  logic [CNT_W-1:0]   i_len1,
    output logic [NUM_REQ-1:0] o_grant,
    output logic               o_gpio,
    output logic               o_busy,
    output logic               o_done
);

    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               gpio, gpio_nxt;
    logic [NUM_REQ-1:0] grant, grant_nxt;
    logic               done, done_nxt;
    logic               ptr, ptr_nxt;
    logic [NUM_REQ-1:0] arb_grant;
    logic [CNT_W-1:0]   len_sel;

    gpio_rr_arb u_arb (
        .req   (i_req),
        .ptr   (ptr),
        .grant (arb_grant)
    );

    // Length is only looked at on the grant edge; the counter holds it after that.
    assign len_sel = arb_grant[1] ? i_len1 : i_len0;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gpio_nxt  = gpio;
        grant_nxt = '0;
        done_nxt  = 1'b0;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (|i_req) begin
                    grant_nxt = arb_grant;
                    ptr_nxt   = rr_next_ptr(arb_grant);
                    if (len_sel != '0) begin
                        state_nxt = HIGH;
                        gpio_nxt  = 1'b1;
                        cnt_nxt   = len_sel - CNT_ONE;
                    end else begin
                        state_nxt = GAP;
                        cnt_nxt   = GAP_LOAD;
                    end
                end
            end
            HIGH: begin
                if (cnt == '0) begin
                    state_nxt = GAP;
                    gpio_nxt  = 1'b0;
                    cnt_nxt   = GAP_LOAD;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                gpio_nxt  = 1'b0;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            cnt   <= '0;
            gpio  <= 1'b0;
            grant <= '0;
            done  <= 1'b0;
            ptr   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            gpio  <= gpio_nxt;
            grant <= grant_nxt;
            done  <= done_nxt;
            ptr   <= ptr_nxt;
        end
    end

    assign o_grant = grant;
    assign o_gpio  = gpio;
    assign o_done  = done;
    assign o_busy  = (state != IDLE);

endmodule

// File: tb/tb_gpio_pulse_arbiter.sv
// Scoreboard bench for gpio_pulse_arbiter: the driver predicts each grant and
// pulse shape, a monitor measures the DUT outputs and compares on o_done.
module tb_gpio_pulse_arbiter;

    localparam int CNT_W = 16;
    localparam int GAP   = 4;

    typedef struct {
        logic [1:0] grant;
        int         len;
        bit         b2b;
    } exp_t;

    logic             clk = 1'b0;
    logic             i_rst;
    logic [1:0]       i_req;
    logic [CNT_W-1:0] i_len0, i_len1;
    logic [1:0]       o_grant;
    logic             o_gpio, o_busy, o_done;

    logic [1:0] i_req4;
    logic [3:0] i_len4;
    logic [1:0] o_grant4;
    logic       o_gpio4, o_busy4, o_done4;

    exp_t exp_q[$];
    int   prio;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    gpio_pulse_arbiter #(.CNT_W(CNT_W), .GAP_CYCLES(GAP)) u_dut (
        .i_clk(clk), .i_rst(i_rst), .i_req(i_req), .i_len0(i_len0), .i_len1(i_len1),
        .o_grant(o_grant), .o_gpio(o_gpio), .o_busy(o_busy), .o_done(o_done)
    );

    gpio_pulse_arbiter #(.CNT_W(4), .GAP_CYCLES(GAP)) u_dut4 (
        .i_clk(clk), .i_rst(i_rst), .i_req(i_req4), .i_len0(i_len4), .i_len1(i_len4),
        .o_grant(o_grant4), .o_gpio(o_gpio4), .o_busy(o_busy4), .o_done(o_done4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Round-robin reference: both requesting -> priority holder wins; otherwise the lone one.
    function automatic int pick(input logic [1:0] r);
        int w;
        if (r == 2'b11) w = prio;
        else if (r[1]) w = 1;
        else w = 0;
        prio = 1 - w;
        return w;
    endfunction

    task automatic push_exp(input int w, input int len, input bit b2b);
        exp_t e;
        e.grant = (w == 1) ? 2'b10 : 2'b01;
        e.len   = len;
        e.b2b   = b2b;
        exp_q.push_back(e);
    endtask

    task automatic wait_grant();
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (o_grant != 2'b00) begin
                ok = 1;
                break;
            end
        end
        check("grant_seen", ok, 1);
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (o_done) begin
                ok = 1;
                break;
            end
        end
        check("done_seen", ok, 1);
    endtask

    task automatic txn(input logic [1:0] r, input int l0, input int l1, input bit chg);
        int w;
        w = pick(r);
        push_exp(w, (w == 1) ? l1 : l0, 1'b0);
        i_req  = r;
        i_len0 = CNT_W'(l0);
        i_len1 = CNT_W'(l1);
        wait_grant();
        i_req = 2'b00;
        if (chg) begin
            i_len0 = CNT_W'($urandom_range(0, 65535));
            i_len1 = CNT_W'($urandom_range(0, 65535));
        end
        wait_done();
    endtask

    function automatic int rand_len();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return 0;
        if (sel == 1) return $urandom_range(100, 300);
        return $urandom_range(1, 12);
    endfunction

    // Monitor: measures each granted sequence and scores it when o_done pulses.
    initial begin : monitor
        bit         prev_g, counting, have_meas;
        int         low_run, meas, gcyc, hcnt, bcnt;
        logic [1:0] gval;
        exp_t       e;
        prev_g = 0; counting = 0; have_meas = 0;
        low_run = 0; meas = 0; gcyc = 0; hcnt = 0; bcnt = 0; gval = '0;
        forever begin
            @(negedge clk);
            if (i_rst) begin
                prev_g = 0; counting = 0; have_meas = 0;
                low_run = 0; gcyc = 0; hcnt = 0; bcnt = 0; gval = '0;
                continue;
            end
            if (o_grant != 2'b00) begin
                gcyc++;
                gval = o_grant;
            end
            if (o_busy) bcnt++;
            if (o_gpio) begin
                hcnt++;
                if (!prev_g && counting) begin
                    meas = low_run;
                    have_meas = 1;
                end
                counting = 0;
            end else begin
                if (prev_g) begin
                    counting = 1;
                    low_run = 0;
                end
                if (counting) low_run++;
            end
            prev_g = o_gpio;
            if (o_done) begin
                check("txn_pending_at_done", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("grant_value", gval, e.grant);
                    check("grant_cycles", gcyc, 1);
                    check("high_width", hcnt, e.len);
                    check("busy_cycles", bcnt, e.len + GAP);
                    if (e.b2b) check("low_interval", have_meas ? meas : -1, GAP + 1);
                end
                gcyc = 0; hcnt = 0; bcnt = 0; have_meas = 0; gval = '0;
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int hc, bc, gc;
        bit seen;
        prio   = 0;
        i_rst  = 1'b1;
        i_req  = 2'b11;
        i_len0 = 3;
        i_len1 = 5;
        i_req4 = 2'b00;
        i_len4 = 4'd0;

        // Requests held during reset must not be granted.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_grant", o_grant, 0);
            check("rst_gpio", o_gpio, 0);
            check("rst_busy", o_busy, 0);
            check("rst_done", o_done, 0);
        end
        @(posedge clk);
        #1 i_rst = 1'b0;
        txn(2'b11, 3, 5, 1'b0);

        txn(2'b01, 3, 0, 1'b0);
        txn(2'b10, 7, 0, 1'b0);
        txn(2'b01, 4, 1, 1'b0);
        i_req  = 2'b01;
        i_len0 = 4;
        void'(pick(2'b01));
        push_exp(0, 4, 1'b0);
        wait_grant();
        i_req  = 2'b00;
        i_len0 = 9;
        wait_done();

        // Contention with requests held: strictly alternating, minimum low gap.
        i_len0 = 2;
        i_len1 = 5;
        i_req  = 2'b11;
        for (int k = 0; k < 4; k++) begin
            int w;
            w = pick(2'b11);
            push_exp(w, (w == 1) ? 5 : 2, k > 0);
        end
        for (int k = 0; k < 4; k++) begin
            wait_grant();
            if (k == 3) i_req = 2'b00;
            wait_done();
        end

        // Abort a long pulse with reset at high cycle 10.
        i_req  = 2'b01;
        i_len0 = 100;
        void'(pick(2'b01));
        push_exp(0, 100, 1'b0);
        wait_grant();
        i_req = 2'b00;
        repeat (9) @(negedge clk);
        check("pre_reset_gpio", o_gpio, 1);
        @(posedge clk);
        #1 i_rst = 1'b1;
        void'(exp_q.pop_back());
        @(posedge clk);
        #1 i_rst = 1'b0;
        prio = 0;
        @(negedge clk);
        check("post_reset_gpio", o_gpio, 0);
        check("post_reset_busy", o_busy, 0);
        check("post_reset_grant", o_grant, 0);
        repeat (5) @(negedge clk);
        txn(2'b11, 6, 8, 1'b0);

        for (int n = 0; n < 40; n++) begin
            txn(2'($urandom_range(1, 3)), rand_len(), rand_len(), 1'($urandom_range(0, 1)));
        end

        // Narrow-counter instance: full-scale length must not wrap.
        @(posedge clk);
        #1;
        i_req4 = 2'b01;
        i_len4 = 4'd15;
        hc = 0; bc = 0; gc = 0; seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_grant4 != 2'b00) begin
                gc++;
                i_req4 = 2'b00;
                i_len4 = 4'd2;
            end
            if (o_gpio4) hc++;
            if (o_busy4) bc++;
            if (o_done4) begin
                seen = 1;
                break;
            end
        end
        check("max_len_done", seen, 1);
        check("max_len_grants", gc, 1);
        check("max_len_high", hc, 15);
        check("max_len_busy", bc, 15 + GAP);

        repeat (10) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
